swt_debounce: RTL and testbench

Multi-channel switch/button input conditioner: the input-side counterpart of the LED toggle counters. Each raw asynchronous switch line is synchronized, debounced against a runtime-programmable stability count, and presented as a clean level plus single-cycle rise/fall pulses. It sits between board switch pins and any logic that consumes `swt` (counter enables, mode selects). The same `i_cntMax` convention is used as the toggle counters: small values for simulation, millisecond-scale values for hardware.

---
 rtl/swt_debounce_if.sv | 31 +++
 rtl/swt_debounce.sv | 100 ++++++++++
 tb/tb_swt_debounce.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/swt_debounce_if.sv
// Signal bundle between raw switch inputs, debounce controls and the
// conditioned level/pulse outputs of swt_debounce.
interface swt_debounce_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32
);
    logic [N_CH-1:0]  swt;
    logic [CNT_W-1:0] i_cntMax;
    logic [N_CH-1:0]  o_level;
    logic [N_CH-1:0]  o_rise;
    logic [N_CH-1:0]  o_fall;
    logic [N_CH-1:0]  o_busy;

    modport master (
        output swt,
        output i_cntMax,
        input  o_level,
        input  o_rise,
        input  o_fall,
        input  o_busy
    );

    modport slave (
        input  swt,
        input  i_cntMax,
        output o_level,
        output o_rise,
        output o_fall,
        output o_busy
    );
endinterface

// File: rtl/swt_debounce.sv
// Multi-channel switch conditioner: 2-flop synchronizer, programmable
// stability counter, debounced level plus one-cycle rise/fall pulses.
module swt_debounce #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           rstb,
    swt_debounce_if.slave  bus
);

    typedef enum logic {IDLE, CHECK} state_t;

    logic [N_CH-1:0]  sync1_p0;
    logic [N_CH-1:0]  sync2_p1;
    logic [N_CH-1:0]  level_all;
    logic [N_CH-1:0]  rise_all;
    logic [N_CH-1:0]  fall_all;
    logic [CNT_W-1:0] thresh;

    // Last count value before an update; a programmed 0 behaves like 1.
    function automatic logic [CNT_W-1:0] last_count(input logic [CNT_W-1:0] cnt_max);
        return (cnt_max == '0) ? '0 : cnt_max - CNT_W'(1);
    endfunction

    assign thresh = last_count(bus.i_cntMax);

    // Stage p0/p1: metastability synchronizer
    always_ff @(posedge clk) begin
        if (!rstb) begin
            sync1_p0 <= '0;
            sync2_p1 <= '0;
        end else begin
            sync1_p0 <= bus.swt;
            sync2_p1 <= sync1_p0;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt_p2;
        logic [CNT_W-1:0] cnt_nxt;
        logic             level_p2;
        logic             level_nxt;
        logic             rise_p2;
        logic             rise_nxt;
        logic             fall_p2;
        logic             fall_nxt;

        assign state = (sync2_p1[i] == level_p2) ? IDLE : CHECK;

        always_comb begin
            cnt_nxt   = '0;
            level_nxt = level_p2;
            rise_nxt  = 1'b0;
            fall_nxt  = 1'b0;
            unique case (state)
                IDLE: begin
                    cnt_nxt = '0;
                end
                CHECK: begin
                    // >= rather than == so a lowered threshold takes effect at once
                    if (cnt_p2 >= thresh) begin
                        level_nxt = sync2_p1[i];
                        rise_nxt  = sync2_p1[i];
                        fall_nxt  = ~sync2_p1[i];
                    end else begin
                        cnt_nxt = cnt_p2 + CNT_W'(1);
                    end
                end
                default: cnt_nxt = '0;
            endcase
        end

        // Stage p2: stability counter, debounced level and edge pulses
        always_ff @(posedge clk) begin
            if (!rstb) begin
                cnt_p2   <= '0;
                level_p2 <= 1'b0;
                rise_p2  <= 1'b0;
                fall_p2  <= 1'b0;
            end else begin
                cnt_p2   <= cnt_nxt;
                level_p2 <= level_nxt;
                rise_p2  <= rise_nxt;
                fall_p2  <= fall_nxt;
            end
        end

        assign level_all[i] = level_p2;
        assign rise_all[i]  = rise_p2;
        assign fall_all[i]  = fall_p2;
    end

    assign bus.o_level = level_all;
    assign bus.o_rise  = rise_all;
    assign bus.o_fall  = fall_all;
    assign bus.o_busy  = sync2_p1 ^ level_all;

endmodule

// File: tb/tb_swt_debounce.sv
// Self-checking bench for swt_debounce: table of single-pulse vectors with an
// event scoreboard, plus directed reset, bounce and threshold-change sequences.
module tb_swt_debounce;

    logic clk;
    logic rstb;
    int   tests;
    int   fails;
    int   cyc;

    swt_debounce_if #(.N_CH(4), .CNT_W(32)) bus ();

    swt_debounce #(.N_CH(4), .CNT_W(32)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ch;
        bit rise;
    } ev_t;

    typedef struct {
        int n;
        int ch;
        int len;
        int rise_e;
        int fall_e;
    } vec_t;

    ev_t  sb[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int at, input int ch, input bit rise);
        ev_t e;
        e.cyc  = at;
        e.ch   = ch;
        e.rise = rise;
        sb.push_back(e);
    endtask

    // One clock: sample after the edge, compare pulses against due scoreboard events.
    task automatic tick();
        logic [3:0] exp_rise;
        logic [3:0] exp_fall;
        @(posedge clk);
        #1;
        cyc++;
        exp_rise = '0;
        exp_fall = '0;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            ev_t e;
            e = sb.pop_front();
            if (e.rise) exp_rise[e.ch] = 1'b1;
            else        exp_fall[e.ch] = 1'b1;
        end
        check("o_rise", 32'(bus.o_rise), 32'(exp_rise));
        check("o_fall", 32'(bus.o_fall), 32'(exp_fall));
    endtask

    task automatic drain_check(input string name);
        check(name, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        int c;
        int neff;
        tests = 0;
        fails = 0;
        cyc   = 0;

        //          n  ch len rise fall   (edges relative to the drive point)
        vecs[0] = '{4, 0, 20, 6, 26};
        vecs[1] = '{0, 2, 10, 3, 13};
        vecs[2] = '{1, 3, 10, 3, 13};
        vecs[3] = '{8, 1, 7, 0, 0};
        vecs[4] = '{8, 1, 8, 10, 18};
        vecs[5] = '{4, 2, 3, 0, 0};
        vecs[6] = '{4, 3, 4, 6, 10};
        vecs[7] = '{2, 0, 2, 4, 6};

        // Reset with all switches high
        rstb         = 1'b0;
        bus.swt      = 4'hF;
        bus.i_cntMax = 32'd4;
        repeat (3) tick();
        check("rst_level", 32'(bus.o_level), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);

        rstb = 1'b1;
        c = cyc;
        for (int i = 0; i < 4; i++) push_ev(c + 6, i, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("rel_level", 32'(bus.o_level), (k >= 6) ? 32'hF : 32'h0);
            check("rel_busy", 32'(bus.o_busy), (k >= 2 && k <= 5) ? 32'hF : 32'h0);
        end
        bus.swt = 4'h0;
        c = cyc;
        for (int i = 0; i < 4; i++) push_ev(c + 6, i, 1'b0);
        repeat (10) tick();
        check("rel_fall_level", 32'(bus.o_level), 32'd0);
        drain_check("rel_drain");

        // Table of single pulses on one channel
        for (int v = 0; v < 8; v++) begin
            bus.i_cntMax = 32'(vecs[v].n);
            neff = (vecs[v].n == 0) ? 1 : vecs[v].n;
            c = cyc;
            bus.swt[vecs[v].ch] = 1'b1;
            if (vecs[v].rise_e != 0) push_ev(c + vecs[v].rise_e, vecs[v].ch, 1'b1);
            if (vecs[v].fall_e != 0) push_ev(c + vecs[v].fall_e, vecs[v].ch, 1'b0);
            repeat (vecs[v].len) tick();
            bus.swt[vecs[v].ch] = 1'b0;
            repeat (neff + 8) tick();
            check($sformatf("vec%0d_level", v), 32'(bus.o_level), 32'd0);
            drain_check($sformatf("vec%0d_drain", v));
        end

        // Bounce on channel 1 then settle high
        bus.i_cntMax = 32'd4;
        for (int p = 0; p < 4; p++) begin
            bus.swt[1] = (p % 2 == 0);
            repeat (2) tick();
        end
        bus.swt[1] = 1'b1;
        push_ev(cyc + 6, 1, 1'b1);
        repeat (12) tick();
        check("bounce_level", 32'(bus.o_level), 32'h2);
        bus.swt[1] = 1'b0;
        push_ev(cyc + 6, 1, 1'b0);
        repeat (10) tick();
        drain_check("bounce_drain");

        // Threshold lowered mid-count on channel 2
        bus.i_cntMax = 32'd100;
        bus.swt[2]   = 1'b1;
        repeat (12) tick();
        check("mid_busy", 32'(bus.o_busy), 32'h4);
        check("mid_level_pre", 32'(bus.o_level), 32'd0);
        bus.i_cntMax = 32'd5;
        push_ev(cyc + 1, 2, 1'b1);
        tick();
        check("mid_level_post", 32'(bus.o_level), 32'h4);
        bus.i_cntMax = 32'd4;
        bus.swt[2]   = 1'b0;
        push_ev(cyc + 6, 2, 1'b0);
        repeat (10) tick();
        drain_check("mid_drain");

        // Reset on the edge that would otherwise complete channel 3's update
        bus.swt[3] = 1'b1;
        repeat (5) tick();
        check("rmid_busy", 32'(bus.o_busy), 32'h8);
        rstb = 1'b0;
        tick();
        check("rmid_level", 32'(bus.o_level), 32'd0);
        check("rmid_busy0", 32'(bus.o_busy), 32'd0);
        bus.swt[3] = 1'b0;
        tick();
        rstb = 1'b1;
        repeat (10) tick();
        check("rmid_after", 32'(bus.o_level), 32'd0);
        drain_check("rmid_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
